// File: rtl/instr_loader.sv
// instr_loader: boot loader packing a little-endian byte stream into 32-bit instruction memory words
module instr_loader #(
    parameter int IMEM_WORDS = 256,
    parameter int ADDR_W = 64,
    localparam int WC_W = $clog2(IMEM_WORDS) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              load_done,
    output logic              err_overflow,
    output logic [WC_W-1:0]   word_count
);
    typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DONE, ERROR} state_t;
    state_t state, state_n;
    logic [1:0] idx;
    logic [31:0] shreg;
    logic [31:0] word_n;
    logic last_q;
    logic accept;
    logic full;
    logic closing;
    assign in_ready = state == IDLE || state == COLLECT;
    assign accept = in_valid && in_ready;
    assign full = word_count == WC_W'(IMEM_WORDS);
    assign closing = idx == 2'd3 || in_last;
    assign word_n = shreg | (32'(in_data) << {idx, 3'b000});
    assign imem_we = state == WRITE;
    assign load_done = state == DONE;
    assign cpu_rst = state != DONE;
    assign err_overflow = state == ERROR;
    // state register
    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end
    // next state: a write cycle always follows the closing byte; DONE and ERROR hold until rst
    always_comb begin
        state_n = state == WRITE ? (last_q ? DONE : COLLECT)
                : accept         ? (full ? ERROR : closing ? WRITE : COLLECT)
                :                  state;
    end
    // byte packing, write word/address capture and word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            shreg      <= '0;
            last_q     <= 1'b0;
            word_count <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            if (accept && !full) begin
                idx   <= closing ? 2'd0 : idx + 2'd1;
                shreg <= closing ? '0 : word_n;
                if (closing) begin
                    imem_wdata <= word_n;
                    imem_addr  <= ADDR_W'({word_count, 2'b00});
                    last_q     <= in_last;
                end
            end
            if (imem_we) word_count <= word_count + WC_W'(1);
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized and directed checks of instr_loader against a packing model
module tb_instr_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic in_ready, imem_we, cpu_rst, load_done, err_overflow;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0] word_count;
    logic s_in_ready, s_imem_we, s_cpu_rst, s_load_done, s_err_overflow;
    logic [63:0] s_imem_addr;
    logic [31:0] s_imem_wdata;
    logic [1:0] s_word_count;
    int vectors = 0;
    int miscompares = 0;
    bit sel = 1'b0;
    logic [95:0] wq[$];
    logic [95:0] wq_s[$];
    logic [7:0] byte_q[$];
    bit last_q[$];
    logic [95:0] exp_q[$];

    instr_loader #(.IMEM_WORDS(256), .ADDR_W(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .load_done(load_done), .err_overflow(err_overflow), .word_count(word_count)
    );

    instr_loader #(.IMEM_WORDS(2), .ADDR_W(64)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(s_in_ready), .imem_we(s_imem_we), .imem_addr(s_imem_addr), .imem_wdata(s_imem_wdata),
        .cpu_rst(s_cpu_rst), .load_done(s_load_done), .err_overflow(s_err_overflow), .word_count(s_word_count)
    );

    always #5 clk = ~clk;

    // write monitor: every memory write seen by either instance, sampled after the edge
    always @(posedge clk) begin
        #1;
        if (imem_we) wq.push_back({imem_addr, imem_wdata});
        if (s_imem_we) wq_s.push_back({s_imem_addr, s_imem_wdata});
    end

    // reference: group bytes four at a time (or up to in_last), little-endian, at consecutive word addresses
    function automatic void build_exp();
        int k = 0;
        int n = 0;
        logic [31:0] w = '0;
        exp_q.delete();
        for (int i = 0; i < byte_q.size(); i++) begin
            w = w + (32'(byte_q[i]) << (8 * k));
            k++;
            if (k == 4 || last_q[i]) begin
                exp_q.push_back({64'(n * 4), w});
                n++;
                w = '0;
                k = 0;
                if (last_q[i]) break;
            end
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_last = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        wq.delete();
        wq_s.delete();
        byte_q.delete();
        last_q.delete();
    endtask

    // offer one byte after `gap` idle cycles (optionally with a spurious in_last) and wait for acceptance
    task automatic send(input logic [7:0] d, input bit l, input int gap, input bit ghost, output int waited);
        in_valid = 1'b0;
        in_last = ghost;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        waited = 0;
        while (!(sel ? s_in_ready : in_ready) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (!(sel ? s_in_ready : in_ready)) begin
            miscompares++;
            $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", waited);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
        byte_q.push_back(d);
        last_q.push_back(l);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        vectors++; if (imem_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b want 0", imem_we); end
        vectors++; if (imem_addr !== 64'd0) begin miscompares++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
        vectors++; if (imem_wdata !== 32'd0) begin miscompares++; $display("FAIL reset_wdata: got %h want 0", imem_wdata); end
        vectors++; if (cpu_rst !== 1'b1) begin miscompares++; $display("FAIL reset_cpu_rst: got %b want 1", cpu_rst); end
        vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", load_done); end
        vectors++; if (err_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err_overflow); end
        vectors++; if (word_count !== 9'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", word_count); end
    endtask

    task automatic test_basic_program();
        logic [7:0] prog [8] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        int w;
        do_reset();
        for (int i = 0; i < 8; i++) send(prog[i], i == 7, 0, 1'b0, w);
        vectors++; if (imem_we !== 1'b1 || load_done !== 1'b0) begin miscompares++; $display("FAIL basic_last_write: we=%b done=%b want we=1 done=0", imem_we, load_done); end
        @(negedge clk);
        vectors++; if (wq.size() != 2) begin miscompares++; $display("FAIL basic_nwrites: got %0d want 2", wq.size()); end
        else begin
            vectors++; if (wq[0] !== {64'd0, 32'h00500513}) begin miscompares++; $display("FAIL basic_w0: got %h want %h", wq[0], {64'd0, 32'h00500513}); end
            vectors++; if (wq[1] !== {64'd4, 32'h00A00593}) begin miscompares++; $display("FAIL basic_w1: got %h want %h", wq[1], {64'd4, 32'h00A00593}); end
        end
        vectors++; if (word_count !== 9'd2) begin miscompares++; $display("FAIL basic_count: got %0d want 2", word_count); end
        vectors++; if (load_done !== 1'b1 || cpu_rst !== 1'b0) begin miscompares++; $display("FAIL basic_done: done=%b cpu_rst=%b want 1/0", load_done, cpu_rst); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL basic_ready_done: got %b want 0", in_ready); end
    endtask

    task automatic test_back_to_back();
        int w;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(8'(i + 1), 1'b0, 0, 1'b0, w);
            vectors++; if (w != (i == 4 ? 1 : 0)) begin miscompares++; $display("FAIL b2b_wait%0d: got %0d want %0d", i, w, i == 4 ? 1 : 0); end
        end
        vectors++; if (wq.size() != 1) begin miscompares++; $display("FAIL b2b_nwrites: got %0d want 1", wq.size()); end
        else begin
            vectors++; if (wq[0] !== {64'd0, 32'h04030201}) begin miscompares++; $display("FAIL b2b_w0: got %h want %h", wq[0], {64'd0, 32'h04030201}); end
        end
        vectors++; if (word_count !== 9'd1 || in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_state: count=%0d ready=%b want 1/1", word_count, in_ready); end
        send(8'h06, 1'b1, 0, 1'b0, w);
        repeat (2) @(negedge clk);
        vectors++; if (wq.size() != 2 || wq[wq.size()-1] !== {64'd4, 32'h00000605}) begin miscompares++; $display("FAIL b2b_fifth_byte: nwrites=%0d last=%h want 2 / %h", wq.size(), wq[wq.size()-1], {64'd4, 32'h00000605}); end
    endtask

    task automatic test_zero_pad();
        logic [7:0] prog [6] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        int w;
        do_reset();
        for (int i = 0; i < 6; i++) send(prog[i], i == 5, 0, 1'b0, w);
        vectors++; if (imem_we !== 1'b1 || load_done !== 1'b0) begin miscompares++; $display("FAIL pad_write_cycle: we=%b done=%b want 1/0", imem_we, load_done); end
        @(negedge clk);
        vectors++; if (imem_we !== 1'b0 || load_done !== 1'b1) begin miscompares++; $display("FAIL pad_done_cycle: we=%b done=%b want 0/1", imem_we, load_done); end
        vectors++; if (wq.size() != 2) begin miscompares++; $display("FAIL pad_nwrites: got %0d want 2", wq.size()); end
        else begin
            vectors++; if (wq[1] !== {64'd4, 32'h0000FFEE}) begin miscompares++; $display("FAIL pad_w1: got %h want %h", wq[1], {64'd4, 32'h0000FFEE}); end
        end
    endtask

    task automatic test_overflow();
        int w;
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) send(8'($urandom), 1'b0, 0, 1'b0, w);
        vectors++; if (s_err_overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_early: got %b want 0", s_err_overflow); end
        send(8'($urandom), 1'b0, 0, 1'b0, w);
        build_exp();
        vectors++; if (s_err_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", s_err_overflow); end
        repeat (4) @(negedge clk);
        vectors++; if (wq_s.size() != 2) begin miscompares++; $display("FAIL ovf_nwrites: got %0d want 2", wq_s.size()); end
        else for (int i = 0; i < 2; i++) begin
            vectors++; if (wq_s[i] !== exp_q[i]) begin miscompares++; $display("FAIL ovf_w%0d: got %h want %h", i, wq_s[i], exp_q[i]); end
        end
        vectors++; if (s_err_overflow !== 1'b1 || s_cpu_rst !== 1'b1 || s_in_ready !== 1'b0 || s_load_done !== 1'b0) begin
            miscompares++; $display("FAIL ovf_sticky: err=%b cpu_rst=%b ready=%b done=%b want 1/1/0/0", s_err_overflow, s_cpu_rst, s_in_ready, s_load_done);
        end
        vectors++; if (s_word_count !== 2'd2) begin miscompares++; $display("FAIL ovf_count: got %0d want 2", s_word_count); end
        sel = 1'b0;
    endtask

    task automatic test_reset_abort();
        int w;
        do_reset();
        send(8'hDE, 1'b0, 0, 1'b0, w);
        send(8'hAD, 1'b0, 0, 1'b0, w);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++; if (wq.size() != 0) begin miscompares++; $display("FAIL abort_no_write: got %0d writes want 0", wq.size()); end
        vectors++; if (in_ready !== 1'b1 || cpu_rst !== 1'b1) begin miscompares++; $display("FAIL abort_state: ready=%b cpu_rst=%b want 1/1", in_ready, cpu_rst); end
        for (int i = 0; i < 4; i++) send(8'h11 * 8'(i + 1), i == 3, 0, 1'b0, w);
        repeat (2) @(negedge clk);
        vectors++; if (wq.size() != 1) begin miscompares++; $display("FAIL abort_nwrites: got %0d want 1", wq.size()); end
        else begin
            vectors++; if (wq[0] !== {64'd0, 32'h44332211}) begin miscompares++; $display("FAIL abort_w0: got %h want %h", wq[0], {64'd0, 32'h44332211}); end
        end
        vectors++; if (load_done !== 1'b1) begin miscompares++; $display("FAIL abort_done: got %b want 1", load_done); end
    endtask

    task automatic test_random_gaps(input int len);
        int w;
        int gap;
        int ghost_at;
        do_reset();
        ghost_at = $urandom_range(1, len - 2);
        for (int i = 0; i < len; i++) begin
            vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL gaps_early_done: byte %0d got %b want 0", i, load_done); end
            gap = (i == ghost_at) ? $urandom_range(1, 3) : $urandom_range(0, 3);
            send(8'($urandom), i == len - 1, gap, i == ghost_at, w);
        end
        build_exp();
        vectors++; if (load_done !== 1'b0) begin miscompares++; $display("FAIL gaps_done_with_write: got %b want 0", load_done); end
        repeat (2) @(negedge clk);
        vectors++; if (wq.size() != exp_q.size()) begin miscompares++; $display("FAIL gaps_nwrites: got %0d want %0d", wq.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            vectors++; if (wq[i] !== exp_q[i]) begin miscompares++; $display("FAIL gaps_w%0d: got %h want %h", i, wq[i], exp_q[i]); end
        end
        vectors++; if (word_count !== 9'(exp_q.size()) || load_done !== 1'b1 || cpu_rst !== 1'b0) begin
            miscompares++; $display("FAIL gaps_final: count=%0d done=%b cpu_rst=%b want %0d/1/0", word_count, load_done, cpu_rst, exp_q.size());
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_basic_program();
        test_back_to_back();
        test_zero_pad();
        test_overflow();
        test_reset_abort();
        for (int r = 0; r < 3; r++) test_random_gaps(16);
        for (int r = 0; r < 6; r++) test_random_gaps($urandom_range(3, 23));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
